sc_accum_ctrl: RTL and testbench

- Sequencing controller for parallel stochastic-bitstream counting.
- Accepts N-bit parallel bitstream beats over a programmable number of accepted cycles and sums the popcount of every beat.
- Returns the total through a valid/ready result handshake.
- Sits between the SNG/bitstream source and the downstream decoder/divider that converts the count back to a probability.

---
 rtl/sc_pkg.sv | 20 ++
 rtl/popcount_n.sv | 32 +++
 rtl/sc_accum_ctrl.sv | 102 ++++++++++
 tb/tb_sc_accum_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and width helpers for the stochastic-bitstream accumulation controller.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sc_ctrl_state_t;

  // Width of a ones count over n bits (range 0..n inclusive).
  function automatic int pc_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Width of a total over up to 2**len_w-1 beats of 2**k bits.
  function automatic int sum_width(input int k, input int len_w);
    return k + len_w;
  endfunction

endpackage

// File: rtl/popcount_n.sv
// Combinational ones count of an N-bit beat, built as a pairwise adder tree.
module popcount_n
  import sc_pkg::*;
#(
  parameter int N    = 8,
  parameter int CNT_W = pc_width(N)
) (
  input  logic [N-1:0]     bits_in,
  output logic [CNT_W-1:0] count
);

  // Leaf level padded to a power of two so every tree level halves cleanly.
  localparam int LEVELS = (N > 1) ? $clog2(N) : 1;
  localparam int LEAVES = 1 << LEVELS;

  logic [CNT_W-1:0] node [2*LEAVES-1];

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < N) begin : g_bit
      assign node[LEAVES-1+i] = CNT_W'(bits_in[i]);
    end else begin : g_pad
      assign node[LEAVES-1+i] = '0;
    end
  end

  for (genvar j = 0; j < LEAVES-1; j++) begin : g_add
    assign node[j] = node[2*j+1] + node[2*j+2];
  end

  assign count = node[0];

endmodule

// File: rtl/sc_accum_ctrl.sv
// Sums the popcount of a programmable number of accepted bitstream beats and
// hands the total downstream over a valid/ready result interface.
//
//   state | meaning
//   IDLE  | waiting for start; no beats accepted
//   RUN   | accepting beats until remaining reaches zero or abort
//   DONE  | result_valid high, result held until result_ready
module sc_accum_ctrl
  import sc_pkg::*;
#(
  parameter int K     = 3,
  parameter int N     = 2**K,
  parameter int LEN_W = 8,
  parameter int SUM_W = sum_width(K, LEN_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic [N-1:0]     bits_in,
  input  logic             bits_valid,
  output logic             bits_ready,
  output logic             busy,
  output logic [SUM_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int PC_W = pc_width(N);

  sc_ctrl_state_t   state, state_nxt;
  logic [SUM_W-1:0] sum, sum_nxt, result_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum_add;
  logic             beat;

  popcount_n #(.N(N), .CNT_W(PC_W)) u_popcount (
    .bits_in (bits_in),
    .count   (pc)
  );

  assign bits_ready   = (state == RUN);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);
  assign beat         = bits_valid && bits_ready;
  assign sum_add      = sum + SUM_W'(pc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sum       <= '0;
      remaining <= '0;
      result    <= '0;
    end else begin
      state     <= state_nxt;
      sum       <= sum_nxt;
      remaining <= remaining_nxt;
      result    <= result_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sum_nxt       = sum;
    remaining_nxt = remaining;
    result_nxt    = result;
    unique case (state)
      IDLE: begin
        if (start) begin
          sum_nxt = '0;
          if (len != '0) begin
            remaining_nxt = len;
            state_nxt     = RUN;
          end else begin
            result_nxt = '0;
            state_nxt  = DONE;
          end
        end
      end
      RUN: begin
        // abort wins over a beat presented in the same cycle
        if (abort) begin
          state_nxt = IDLE;
        end else if (beat) begin
          sum_nxt       = sum_add;
          remaining_nxt = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            result_nxt = sum_add;
            state_nxt  = DONE;
          end
        end
      end
      DONE: begin
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sc_accum_ctrl.sv
// Directed bench for sc_accum_ctrl with hand-computed expected totals.
module tb_sc_accum_ctrl;

  localparam int K     = 3;
  localparam int N     = 8;
  localparam int LEN_W = 8;
  localparam int SUM_W = 11;

  logic             clk = 1'b0;
  logic             reset, start, abort, bits_valid, result_ready;
  logic [LEN_W-1:0] len;
  logic [N-1:0]     bits_in;
  logic             bits_ready, busy, result_valid;
  logic [SUM_W-1:0] result;

  int n_chk  = 0;
  int n_pass = 0;

  sc_accum_ctrl #(.K(K), .N(N), .LEN_W(LEN_W), .SUM_W(SUM_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .len          (len),
    .abort        (abort),
    .bits_in      (bits_in),
    .bits_valid   (bits_valid),
    .bits_ready   (bits_ready),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Outputs are sampled 1ns after the active edge; inputs change at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [N-1:0] b, input logic v);
    bits_in    = b;
    bits_valid = v;
    tick();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, bits_ready, 0);
    chk({tag, "_rv"}, result_valid, 0);
  endtask

  initial begin
    logic [5:0] vpat;
    reset = 1'b1; start = 1'b0; abort = 1'b0; bits_valid = 1'b0;
    result_ready = 1'b0; len = '0; bits_in = '0;
    #1;
    tick(); tick();
    reset = 1'b0;
    check_idle("rst");
    chk("rst_result", result, 0);

    // Basic run: 8 + 4 + 1 + 0 = 13
    result_ready = 1'b1;
    start = 1'b1; len = 8'd4; tick(); start = 1'b0;
    chk("basic_run_ready", bits_ready, 1);
    chk("basic_run_busy", busy, 1);
    beat(8'hFF, 1); beat(8'h0F, 1); beat(8'h01, 1);
    chk("basic_not_yet", result_valid, 0);
    beat(8'h00, 1);
    bits_valid = 1'b0;
    chk("basic_rv", result_valid, 1);
    chk("basic_result", result, 13);
    chk("basic_done_ready", bits_ready, 0);
    tick();
    check_idle("basic_after");
    chk("basic_result_kept", result, 13);

    // Stalls and backpressure: three accepted 8'hAA beats = 12
    result_ready = 1'b0;
    start = 1'b1; len = 8'd3; tick(); start = 1'b0;
    vpat = 6'b101001;
    for (int i = 0; i < 6; i++) beat(8'hAA, vpat[i]);
    bits_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rv", result_valid, 1);
      chk("stall_result", result, 12);
      // a start pulse in DONE must not disturb anything
      start = (i == 2); len = 8'd7; abort = (i == 3);
      tick();
    end
    start = 1'b0; abort = 1'b0;
    chk("stall_rv_hold", result_valid, 1);
    chk("stall_result_hold", result, 12);
    result_ready = 1'b1; tick();
    check_idle("stall_hs");

    // Zero length run
    result_ready = 1'b0;
    start = 1'b1; len = 8'd0; tick(); start = 1'b0;
    chk("zero_rv", result_valid, 1);
    chk("zero_result", result, 0);
    chk("zero_ready", bits_ready, 0);
    chk("zero_busy", busy, 1);
    tick();
    chk("zero_ready_2", bits_ready, 0);
    result_ready = 1'b1; tick();
    check_idle("zero_hs");

    // Abort with a simultaneous valid beat
    start = 1'b1; len = 8'd10; tick(); start = 1'b0;
    beat(8'hFF, 1); beat(8'hFF, 1); beat(8'hFF, 1);
    abort = 1'b1; beat(8'hFF, 1); abort = 1'b0; bits_valid = 1'b0;
    check_idle("abort");
    tick();
    chk("abort_no_rv", result_valid, 0);
    chk("abort_result_kept", result, 0);
    start = 1'b1; len = 8'd1; tick(); start = 1'b0;
    beat(8'h03, 1); bits_valid = 1'b0;
    chk("post_abort_rv", result_valid, 1);
    chk("post_abort_result", result, 2);
    tick();
    check_idle("post_abort_hs");

    // Full-length run: 255 * 8 = 2040
    result_ready = 1'b0;
    start = 1'b1; len = 8'd255; tick(); start = 1'b0;
    for (int i = 0; i < 254; i++) beat(8'hFF, 1);
    chk("sat_not_yet", result_valid, 0);
    beat(8'hFF, 1); bits_valid = 1'b0;
    chk("sat_rv", result_valid, 1);
    chk("sat_result", result, 2040);
    result_ready = 1'b1; tick();
    check_idle("sat_hs");

    // Reset mid-run
    start = 1'b1; len = 8'd5; tick(); start = 1'b0;
    beat(8'hFF, 1); beat(8'hFF, 1);
    reset = 1'b1; beat(8'hFF, 1); reset = 1'b0; bits_valid = 1'b0;
    check_idle("midrst");
    chk("midrst_result", result, 0);

    // start during RUN must not reload len
    result_ready = 1'b0;
    start = 1'b1; len = 8'd3; tick();
    len = 8'd1; beat(8'h0F, 1); start = 1'b0;
    chk("runstart_rv", result_valid, 0);
    chk("runstart_busy", busy, 1);
    beat(8'h0F, 1);
    chk("runstart_rv2", result_valid, 0);
    beat(8'h0F, 1); bits_valid = 1'b0;
    chk("runstart_rv3", result_valid, 1);
    chk("runstart_result", result, 12);
    result_ready = 1'b1; tick();
    check_idle("runstart_hs");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
